// File: rtl/mips_ctrl_pkg.sv
// Opcode, ALUOp, mux-select encodings and the state enum shared by the multicycle controller.
// MULTICYCLE_CONTROL_JUMP_EN adds the jump opcode, jump PC source and the JUMP state.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'h02;
`endif

  localparam logic [2:0] ALUOP_RTYPE = 3'b111;
  localparam logic [2:0] ALUOP_ADD   = 3'b100;
  localparam logic [2:0] ALUOP_OR    = 3'b101;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;

  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_SEXT  = 2'd2;
  localparam logic [1:0] SRCB_SHIFT = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
`endif

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I,
    MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, FAULT
`ifdef MULTICYCLE_CONTROL_JUMP_EN
    , JUMP
`endif
  } state_t;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCondEq;
    logic       pcWriteCondNe;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic [2:0] aluCode;
    logic       illegalOp;
    logic       fault;
  } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts MemReady=0 cycles in a wait state and flags the
// cycle on which the MEM_TIMEOUT-th consecutive wait cycle occurs.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (waiting) begin
      count <= count + CW'(1);
    end
  end

  // Count has already seen MEM_TIMEOUT-1 stalls, so this stall is the last allowed.
  assign timeout = waiting && (count == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: fetch/decode/execute FSM with memory-timeout fault.
// MULTICYCLE_CONTROL_JUMP_EN enables the J opcode (JUMP state); otherwise 0x02 is illegal.
module multicycle_control import mips_ctrl_pkg::*; #(
  parameter int ALUOP_WIDTH  = 3,
  parameter int MEM_TIMEOUT  = 15,
  parameter int RETIRE_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              OP,
  input  logic                    MemReady,
  output logic                    PCWrite,
  output logic                    PCWriteCondEQ,
  output logic                    PCWriteCondNE,
  output logic                    IorD,
  output logic                    MemRead,
  output logic                    MemWrite,
  output logic                    IRWrite,
  output logic                    RegDst,
  output logic                    MemtoReg,
  output logic                    RegWrite,
  output logic                    ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              PCSource,
  output logic [ALUOP_WIDTH-1:0]  ALUOp,
  output logic                    IllegalOp,
  output logic                    Fault,
  output logic [RETIRE_WIDTH-1:0] Retired
);

  state_t                  state, stateNext;
  ctrl_t                   ctrl;
  logic                    retire;
  logic [5:0]              opReg;
  logic [RETIRE_WIDTH-1:0] retired;
  logic                    memWaiting, memTimeout, timerClear;

  assign memWaiting = (state == FETCH || state == MEM_RD || state == MEM_WR) && !MemReady;
  assign timerClear = (stateNext != state) &&
                      (stateNext == FETCH || stateNext == MEM_RD || stateNext == MEM_WR);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) uTimer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timerClear),
    .waiting (memWaiting),
    .timeout (memTimeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      opReg   <= '0;
      retired <= '0;
    end else begin
      state <= stateNext;
      if (state == DECODE) opReg <= OP;
      if (retire) retired <= retired + RETIRE_WIDTH'(1);
    end
  end

  always_comb begin
    stateNext = state;
    ctrl      = '0;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        ctrl.memRead  = 1'b1;
        ctrl.aluSrcB  = SRCB_FOUR;
        ctrl.aluCode  = ALUOP_ADD;
        ctrl.pcSource = PCSRC_ALU;
        if (MemReady) begin
          ctrl.irWrite = 1'b1;
          ctrl.pcWrite = 1'b1;
          stateNext    = DECODE;
        end else if (memTimeout) begin
          stateNext = FAULT;
        end
      end
      DECODE: begin
        ctrl.aluSrcB = SRCB_SHIFT;
        ctrl.aluCode = ALUOP_ADD;
        case (OP)
          OP_RTYPE:       stateNext = EXEC_R;
          OP_ADDI, OP_ORI: stateNext = EXEC_I;
          OP_LW, OP_SW:   stateNext = MEM_ADDR;
          OP_BEQ, OP_BNE: stateNext = BRANCH;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
          OP_J:           stateNext = JUMP;
`endif
          default: begin
            ctrl.illegalOp = 1'b1;
            stateNext      = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_REG;
        ctrl.aluCode = ALUOP_RTYPE;
        stateNext    = WB_R;
      end
      WB_R: begin
        ctrl.regDst   = 1'b1;
        ctrl.regWrite = 1'b1;
        retire        = 1'b1;
        stateNext     = FETCH;
      end
      EXEC_I: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_SEXT;
        ctrl.aluCode = (opReg == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
        stateNext    = WB_I;
      end
      WB_I: begin
        ctrl.regWrite = 1'b1;
        retire        = 1'b1;
        stateNext     = FETCH;
      end
      MEM_ADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_SEXT;
        ctrl.aluCode = ALUOP_ADD;
        stateNext    = (opReg == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
        if (MemReady)        stateNext = MEM_WB;
        else if (memTimeout) stateNext = FAULT;
      end
      MEM_WB: begin
        ctrl.memtoReg = 1'b1;
        ctrl.regWrite = 1'b1;
        retire        = 1'b1;
        stateNext     = FETCH;
      end
      MEM_WR: begin
        ctrl.memWrite = 1'b1;
        ctrl.iorD     = 1'b1;
        if (MemReady) begin
          retire    = 1'b1;
          stateNext = FETCH;
        end else if (memTimeout) begin
          stateNext = FAULT;
        end
      end
      BRANCH: begin
        ctrl.aluSrcA       = 1'b1;
        ctrl.aluSrcB       = SRCB_REG;
        ctrl.aluCode       = ALUOP_SUB;
        ctrl.pcSource      = PCSRC_ALUOUT;
        ctrl.pcWriteCondEq = (opReg == OP_BEQ);
        ctrl.pcWriteCondNe = (opReg == OP_BNE);
        retire             = 1'b1;
        stateNext          = FETCH;
      end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      JUMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
        retire        = 1'b1;
        stateNext     = FETCH;
      end
`endif
      FAULT: ctrl.fault = 1'b1;
      default: stateNext = FETCH;
    endcase
    // Reset silences every output combinationally so nothing is written in the reset cycle.
    if (reset) begin
      ctrl   = '0;
      retire = 1'b0;
    end
  end

  assign PCWrite       = ctrl.pcWrite;
  assign PCWriteCondEQ = ctrl.pcWriteCondEq;
  assign PCWriteCondNE = ctrl.pcWriteCondNe;
  assign IorD          = ctrl.iorD;
  assign MemRead       = ctrl.memRead;
  assign MemWrite      = ctrl.memWrite;
  assign IRWrite       = ctrl.irWrite;
  assign RegDst        = ctrl.regDst;
  assign MemtoReg      = ctrl.memtoReg;
  assign RegWrite      = ctrl.regWrite;
  assign ALUSrcA       = ctrl.aluSrcA;
  assign ALUSrcB       = ctrl.aluSrcB;
  assign PCSource      = ctrl.pcSource;
  assign ALUOp         = ALUOP_WIDTH'(ctrl.aluCode);
  assign IllegalOp     = ctrl.illegalOp;
  assign Fault         = ctrl.fault;
  assign Retired       = retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control words are queued by
// the stimulus process and checked by an independent negedge monitor.
module tb_multicycle_control;

  localparam int AW = 4;
  localparam int RW = 3;

  typedef struct packed {
    logic pcW, condEq, condNe, iorD, memRd, memWr, irW, regDst, memToReg, regW, srcA;
    logic [1:0] srcB;
    logic [1:0] pcSrc;
    logic [AW-1:0] aluOp;
    logic ill, flt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] OP = 6'h00;
  logic MemReady = 1'b0;
  logic PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite;
  logic RegDst, MemtoReg, RegWrite, ALUSrcA, IllegalOp, Fault;
  logic [1:0] ALUSrcB, PCSource;
  logic [AW-1:0] ALUOp;
  logic [RW-1:0] Retired;

  multicycle_control #(.ALUOP_WIDTH(AW), .MEM_TIMEOUT(4), .RETIRE_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .OP(OP), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .IllegalOp(IllegalOp), .Fault(Fault), .Retired(Retired)
  );

  always #5 clk = ~clk;

  exp_t          qCtrl[$];
  logic [RW-1:0] qRet[$];
  string         qName[$];
  int            nVec = 0;
  int            nFail = 0;
  logic [RW-1:0] expRet = '0;
  localparam logic [5:0] JUNK = 6'h2A;

  function automatic exp_t fZero();
    exp_t e = '0;
    return e;
  endfunction
  function automatic exp_t fFetch(input logic rdy);
    exp_t e = '0;
    e.memRd = 1; e.srcB = 2'd1; e.aluOp = 4'b0100; e.irW = rdy; e.pcW = rdy;
    return e;
  endfunction
  function automatic exp_t fDecode(input logic ill);
    exp_t e = '0;
    e.srcB = 2'd3; e.aluOp = 4'b0100; e.ill = ill;
    return e;
  endfunction
  function automatic exp_t fExecR();
    exp_t e = '0;
    e.srcA = 1; e.srcB = 2'd0; e.aluOp = 4'b0111;
    return e;
  endfunction
  function automatic exp_t fExecI(input logic isOr);
    exp_t e = '0;
    e.srcA = 1; e.srcB = 2'd2; e.aluOp = isOr ? 4'b0101 : 4'b0100;
    return e;
  endfunction
  function automatic exp_t fMemAddr();
    exp_t e = '0;
    e.srcA = 1; e.srcB = 2'd2; e.aluOp = 4'b0100;
    return e;
  endfunction
  function automatic exp_t fWb(input logic rd, input logic m2r);
    exp_t e = '0;
    e.regW = 1; e.regDst = rd; e.memToReg = m2r;
    return e;
  endfunction
  function automatic exp_t fMem(input logic wr);
    exp_t e = '0;
    e.iorD = 1; e.memRd = !wr; e.memWr = wr;
    return e;
  endfunction
  function automatic exp_t fBranch(input logic ne);
    exp_t e = '0;
    e.srcA = 1; e.srcB = 2'd0; e.aluOp = 4'b0001; e.pcSrc = 2'd1; e.condEq = !ne; e.condNe = ne;
    return e;
  endfunction
  function automatic exp_t fJump();
    exp_t e = '0;
    e.pcW = 1; e.pcSrc = 2'd2;
    return e;
  endfunction
  function automatic exp_t fFault();
    exp_t e = '0;
    e.flt = 1;
    return e;
  endfunction

  task automatic step(input logic [5:0] op, input logic rdy, input logic rst,
                      input exp_t e, input string n);
    OP = op; MemReady = rdy; reset = rst;
    qCtrl.push_back(e); qRet.push_back(expRet); qName.push_back(n);
    @(posedge clk); #1;
  endtask

  task automatic doFetch(input int waits);
    for (int i = 0; i < waits; i++) step(JUNK, 1'b0, 1'b0, fFetch(1'b0), "fetchWait");
    step(JUNK, 1'b1, 1'b0, fFetch(1'b1), "fetch");
  endtask

  task automatic retireOne();
    expRet = expRet + 3'd1;
  endtask

  always @(negedge clk) begin
    if (qCtrl.size() != 0) begin
      exp_t e, a;
      logic [RW-1:0] r;
      string n;
      e = qCtrl.pop_front(); r = qRet.pop_front(); n = qName.pop_front();
      a = {PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp, Fault};
      nVec++;
      if (a !== e || Retired !== r) begin
        nFail++;
        $display("FAIL %s: got ctrl=%h retired=%0d, want ctrl=%h retired=%0d", n, a, Retired, e, r);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    step(JUNK, 1'b1, 1'b1, fZero(), "resetHeld");

    // ADD: 4 cycles, retires in WB_R
    doFetch(0);
    step(6'h00, 1'b1, 1'b0, fDecode(1'b0), "addDecode");
    step(JUNK, 1'b1, 1'b0, fExecR(), "addExecR");
    step(JUNK, 1'b1, 1'b0, fWb(1'b1, 1'b0), "addWbR"); retireOne();

    // LW: three memory stalls in MEM_RD, 8 cycles total
    doFetch(0);
    step(6'h23, 1'b1, 1'b0, fDecode(1'b0), "lwDecode");
    step(JUNK, 1'b0, 1'b0, fMemAddr(), "lwMemAddr");
    for (int i = 0; i < 3; i++) step(JUNK, 1'b0, 1'b0, fMem(1'b0), "lwMemRdWait");
    step(JUNK, 1'b1, 1'b0, fMem(1'b0), "lwMemRd");
    step(JUNK, 1'b1, 1'b0, fWb(1'b0, 1'b1), "lwMemWb"); retireOne();

    // ADDI with fetch stalls; OP changes to ORI after DECODE must not affect ALUOp
    doFetch(2);
    step(6'h08, 1'b1, 1'b0, fDecode(1'b0), "addiDecode");
    step(6'h0D, 1'b1, 1'b0, fExecI(1'b0), "addiExecI");
    step(6'h0D, 1'b1, 1'b0, fWb(1'b0, 1'b0), "addiWbI"); retireOne();

    doFetch(0);
    step(6'h0D, 1'b1, 1'b0, fDecode(1'b0), "oriDecode");
    step(6'h08, 1'b1, 1'b0, fExecI(1'b1), "oriExecI");
    step(JUNK, 1'b1, 1'b0, fWb(1'b0, 1'b0), "oriWbI"); retireOne();

    // SW with one stall; retires on the completing MEM_WR cycle
    doFetch(0);
    step(6'h2B, 1'b1, 1'b0, fDecode(1'b0), "swDecode");
    step(6'h23, 1'b1, 1'b0, fMemAddr(), "swMemAddr");
    step(JUNK, 1'b0, 1'b0, fMem(1'b1), "swMemWrWait");
    step(JUNK, 1'b1, 1'b0, fMem(1'b1), "swMemWr"); retireOne();

    doFetch(0);
    step(6'h04, 1'b1, 1'b0, fDecode(1'b0), "beqDecode");
    step(6'h05, 1'b1, 1'b0, fBranch(1'b0), "beqBranch"); retireOne();

    doFetch(0);
    step(6'h05, 1'b1, 1'b0, fDecode(1'b0), "bneDecode");
    step(6'h04, 1'b1, 1'b0, fBranch(1'b1), "bneBranch"); retireOne();

    // Illegal opcode: one-cycle pulse, straight back to FETCH, no retire
    doFetch(0);
    step(6'h3F, 1'b1, 1'b0, fDecode(1'b1), "illDecode");

    doFetch(0);
`ifdef MULTICYCLE_CONTROL_JUMP_EN
    step(6'h02, 1'b1, 1'b0, fDecode(1'b0), "jDecode");
    step(JUNK, 1'b1, 1'b0, fJump(), "jJump"); retireOne();
`else
    step(6'h02, 1'b1, 1'b0, fDecode(1'b1), "jIllegal");
`endif

    // ADD again: Retired wraps through 2^RW
    doFetch(0);
    step(6'h00, 1'b1, 1'b0, fDecode(1'b0), "add2Decode");
    step(JUNK, 1'b1, 1'b0, fExecR(), "add2ExecR");
    step(JUNK, 1'b1, 1'b0, fWb(1'b1, 1'b0), "add2WbR"); retireOne();

    // Reset in MEM_WR with MemReady=1: no write, no retire, back to FETCH
    doFetch(0);
    step(6'h2B, 1'b1, 1'b0, fDecode(1'b0), "swrDecode");
    step(JUNK, 1'b1, 1'b0, fMemAddr(), "swrMemAddr");
    step(JUNK, 1'b1, 1'b1, fZero(), "swrResetInWr");
    expRet = '0;
    step(JUNK, 1'b1, 1'b0, fFetch(1'b1), "fetchAfterReset");
    step(6'h3F, 1'b1, 1'b0, fDecode(1'b1), "illAfterReset");

    // Timeout: four stalls in FETCH then sticky FAULT until reset
    for (int i = 0; i < 4; i++) step(JUNK, 1'b0, 1'b0, fFetch(1'b0), "toFetchWait");
    step(JUNK, 1'b0, 1'b0, fFault(), "toFault");
    step(JUNK, 1'b1, 1'b0, fFault(), "toFaultSticky");
    step(JUNK, 1'b1, 1'b1, fZero(), "toReset");
    step(JUNK, 1'b1, 1'b0, fFetch(1'b1), "toFetchAfterReset");

    if (qCtrl.size() != 0) begin
      nVec++;
      nFail++;
      $display("FAIL drain: got %0d pending, want 0", qCtrl.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
